// File: rtl/split_responder_slave.sv
// split_responder_slave: byte-memory bus responder; writes complete at once,
// reads either complete directly or are split and returned after a re-grant.
module split_responder_slave #(
   parameter int ADDR_W        = 4,
   parameter bit SPLIT_EN      = 1'b1,
   parameter int SPLIT_LATENCY = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic              s_mode,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [7:0]        s_wdata,
   output logic              s_ready,
   output logic              s_ack,
   output logic [7:0]        s_rdata,
   output logic              s_rdata_valid,
   output logic              s_split_ack,
   output logic              s_split_req,
   input  logic              s_split_grant,
   output logic [7:0]        last_write
);
   localparam int CNT_W = (SPLIT_LATENCY > 0) ? $clog2(SPLIT_LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0] LAT = CNT_W'(SPLIT_LATENCY);

   typedef enum logic [2:0] {IDLE, WR_ACK, RD_DIRECT, SPLIT_WAIT, SPLIT_REQ, RD_RETURN} state_t;

   state_t           r_state, w_next;
   logic [7:0]       r_mem [2**ADDR_W];
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_rdata, r_last;
   logic             r_split_ack;
   logic             w_accept;

   assign w_accept = s_valid && (r_state == IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       if (s_valid) w_next = s_mode ? WR_ACK : (SPLIT_EN ? SPLIT_WAIT : RD_DIRECT);
         SPLIT_WAIT: if (r_cnt == '0) w_next = SPLIT_REQ;
         SPLIT_REQ:  if (s_split_grant) w_next = RD_RETURN;
         default:    w_next = IDLE;
      endcase
   end

   // read data is snapshotted at accept, so the returned byte is the accept-time content
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rdata     <= '0;
         r_last      <= '0;
         r_split_ack <= 1'b0;
         r_mem       <= '{default: '0};
      end else begin
         r_state     <= w_next;
         r_split_ack <= w_accept && !s_mode && SPLIT_EN;
         if (r_state == SPLIT_WAIT && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
         if (w_accept && s_mode) begin
            r_mem[s_addr] <= s_wdata;
            r_last        <= s_wdata;
         end
         if (w_accept && !s_mode) begin
            r_rdata <= r_mem[s_addr];
            r_cnt   <= LAT;
         end
      end
   end

   assign s_ready       = (r_state == IDLE);
   assign s_ack         = (r_state == WR_ACK) || (r_state == RD_DIRECT) || (r_state == RD_RETURN);
   assign s_rdata_valid = (r_state == RD_DIRECT) || (r_state == RD_RETURN);
   assign s_rdata       = r_rdata;
   assign s_split_ack   = r_split_ack;
   assign s_split_req   = (r_state == SPLIT_REQ);
   assign last_write    = r_last;
endmodule

// File: tb/tb_split_responder_slave.sv
// tb_split_responder_slave: three responder configurations (split L=8, direct, split L=0)
// driven by a vector table plus hand sequences; read data checked through a scoreboard.
module tb_split_responder_slave;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid [3], mode [3], grant [3];
   logic [3:0] addr [3];
   logic [7:0] wdata [3];
   logic       ready [3], ack [3], rvalid [3], sack [3], sreq [3];
   logic [7:0] rdata [3], lastw [3];
   int         total = 0, bad = 0;

   typedef struct { int k; logic [7:0] d; } exp_t;
   typedef struct { int k; logic mode; logic [3:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;
   exp_t sb [$];
   vec_t tv [13];

   always #5 clk = ~clk;

   split_responder_slave #(.ADDR_W(4), .SPLIT_EN(1'b1), .SPLIT_LATENCY(8)) u_s8 (
      .clk(clk), .rst_n(rst_n), .s_valid(valid[0]), .s_mode(mode[0]), .s_addr(addr[0]),
      .s_wdata(wdata[0]), .s_ready(ready[0]), .s_ack(ack[0]), .s_rdata(rdata[0]),
      .s_rdata_valid(rvalid[0]), .s_split_ack(sack[0]), .s_split_req(sreq[0]),
      .s_split_grant(grant[0]), .last_write(lastw[0]));
   split_responder_slave #(.ADDR_W(4), .SPLIT_EN(1'b0), .SPLIT_LATENCY(8)) u_dir (
      .clk(clk), .rst_n(rst_n), .s_valid(valid[1]), .s_mode(mode[1]), .s_addr(addr[1]),
      .s_wdata(wdata[1]), .s_ready(ready[1]), .s_ack(ack[1]), .s_rdata(rdata[1]),
      .s_rdata_valid(rvalid[1]), .s_split_ack(sack[1]), .s_split_req(sreq[1]),
      .s_split_grant(grant[1]), .last_write(lastw[1]));
   split_responder_slave #(.ADDR_W(4), .SPLIT_EN(1'b1), .SPLIT_LATENCY(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .s_valid(valid[2]), .s_mode(mode[2]), .s_addr(addr[2]),
      .s_wdata(wdata[2]), .s_ready(ready[2]), .s_ack(ack[2]), .s_rdata(rdata[2]),
      .s_rdata_valid(rvalid[2]), .s_split_ack(sack[2]), .s_split_req(sreq[2]),
      .s_split_grant(grant[2]), .last_write(lastw[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rd(input int k, input logic [7:0] d);
      exp_t e;
      e.k = k;
      e.d = d;
      sb.push_back(e);
   endtask

   // holds the request until accepted; returns in the cycle after the accept edge
   task automatic issue(input int k, input logic m, input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      valid[k] = 1'b1;
      mode[k]  = m;
      addr[k]  = a;
      wdata[k] = d;
      while (!ready[k] && n < 100) begin
         tick();
         n++;
      end
      chk("accept_timeout", 32'(n < 100), 1);
      tick();
      valid[k] = 1'b0;
   endtask

   task automatic wait_req(input int k);
      int n = 0;
      while (!sreq[k] && n < 100) begin
         tick();
         n++;
      end
      chk("split_req_timeout", 32'(n < 100), 1);
   endtask

   task automatic run_vec(input vec_t v);
      if (!v.mode) expect_rd(v.k, v.exp);
      issue(v.k, v.mode, v.addr, v.wdata);
      if (v.mode) begin
         chk("vec_wr_ack", ack[v.k], 1);
         tick();
         chk("vec_last_write", lastw[v.k], v.exp);
      end else if (v.k == 1) begin
         chk("vec_direct_strobes", {ack[1], rvalid[1], sack[1]}, 3'b110);
         tick();
      end else begin
         chk("vec_split_ack", {sack[v.k], rvalid[v.k]}, 2'b10);
         wait_req(v.k);
         grant[v.k] = 1'b1;
         tick();
         grant[v.k] = 1'b0;
         chk("vec_split_return", {ack[v.k], rvalid[v.k], sreq[v.k]}, 3'b110);
         tick();
      end
   endtask

   // every read strobe must match the oldest outstanding expectation
   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rvalid[k]) begin
               if (sb.size() == 0 || sb[0].k != k) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_rdata_valid inst%0d: got strobe with data %0h expected none", k, rdata[k]);
               end else begin
                  chk($sformatf("rdata_inst%0d", k), rdata[k], sb[0].d);
                  void'(sb.pop_front());
               end
            end
         end
      end
   endtask

   initial begin
      int n;
      tv = '{
         '{1, 1'b1, 4'd15, 8'h5A, 8'h5A}, '{1, 1'b0, 4'd15, 8'h00, 8'h5A},
         '{1, 1'b1, 4'd0,  8'h11, 8'h11}, '{1, 1'b0, 4'd0,  8'h00, 8'h11},
         '{1, 1'b0, 4'd7,  8'h00, 8'h00}, '{1, 1'b1, 4'd15, 8'hFF, 8'hFF},
         '{1, 1'b0, 4'd15, 8'h00, 8'hFF}, '{2, 1'b1, 4'd9,  8'hC3, 8'hC3},
         '{2, 1'b0, 4'd9,  8'h00, 8'hC3}, '{2, 1'b0, 4'd2,  8'h00, 8'h00},
         '{0, 1'b0, 4'd3,  8'h00, 8'h3C}, '{0, 1'b1, 4'd5,  8'h77, 8'h77},
         '{0, 1'b0, 4'd5,  8'h00, 8'h00}};
      for (int k = 0; k < 3; k++) begin
         valid[k] = 1'b0; mode[k] = 1'b0; addr[k] = '0; wdata[k] = '0; grant[k] = 1'b0;
      end
      fork monitor(); join_none
      repeat (3) tick();
      chk("reset_strobes", {ready[0], ack[0], rvalid[0], sack[0], sreq[0]}, 5'b10000);
      chk("reset_rdata", rdata[0], 0);
      chk("reset_last_write", lastw[0], 0);
      rst_n = 1'b1;
      tick();
      // write timing: ack one cycle after accept, ready low exactly one cycle
      issue(0, 1'b1, 4'd3, 8'hA5);
      chk("wr_T1", {ack[0], ready[0]}, 2'b10);
      tick();
      chk("wr_T2", {ack[0], ready[0]}, 2'b01);
      chk("wr_last_write", lastw[0], 8'hA5);
      // split read L=8 with a late grant and a write held pending behind it
      expect_rd(0, 8'hA5);
      issue(0, 1'b0, 4'd3, 8'h00);
      chk("split_T1", {sack[0], ack[0], rvalid[0]}, 3'b100);
      valid[0] = 1'b1; mode[0] = 1'b1; addr[0] = 4'd3; wdata[0] = 8'h3C;
      n = 0;
      for (int i = 2; i <= 9; i++) begin
         tick();
         if (sreq[0] || ready[0] || sack[0]) n++;
      end
      chk("split_wait_quiet", n, 0);
      tick();
      chk("split_req_T10", {sreq[0], ready[0]}, 2'b10);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!sreq[0] || ready[0]) n++;
      end
      chk("split_req_held", n, 0);
      grant[0] = 1'b1;
      tick();
      grant[0] = 1'b0;
      chk("split_return", {ack[0], rvalid[0], sreq[0], ready[0]}, 4'b1100);
      chk("held_write_not_taken", lastw[0], 8'hA5);
      tick();
      chk("held_write_ready", ready[0], 1);
      tick();
      valid[0] = 1'b0;
      chk("held_write_ack", ack[0], 1);
      tick();
      chk("held_write_last", lastw[0], 8'h3C);
      for (int i = 0; i < 11; i++) run_vec(tv[i]);
      // L=0 with grant already high: req at T+2, data at T+3
      expect_rd(2, 8'hC3);
      grant[2] = 1'b1;
      issue(2, 1'b0, 4'd9, 8'h00);
      chk("l0_T1", {sack[2], sreq[2], rvalid[2]}, 3'b100);
      tick();
      chk("l0_T2", {sreq[2], rvalid[2]}, 2'b10);
      tick();
      chk("l0_T3", {ack[2], rvalid[2], sreq[2]}, 3'b110);
      grant[2] = 1'b0;
      tick();
      chk("l0_T4", {ready[2], rvalid[2]}, 2'b10);
      // reset during SPLIT_REQ aborts the read and clears memory
      run_vec(tv[11]);
      issue(0, 1'b0, 4'd5, 8'h00);
      wait_req(0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_strobes", {ready[0], ack[0], rvalid[0], sack[0], sreq[0]}, 5'b10000);
      chk("rst_async_last_write", lastw[0], 0);
      chk("rst_async_rdata", rdata[0], 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_release_ready", ready[0], 1);
      repeat (12) tick();
      run_vec(tv[12]);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
